// File: rtl/digital_sine_gen.sv
// Free-running 12-bit offset-binary sine source for the DAC path.
// 256-point wave unfolded from a 65-entry quarter-wave ROM.
module digital_sine_gen #(
    parameter int CLK_DIV = 488,
    parameter int STEP    = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [11:0] data
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [7:0] STEP_W = 8'(STEP);

    logic [CW-1:0] div_cnt;
    logic [7:0]    idx;
    logic [7:0]    idx_nxt;
    logic [6:0]    q_addr;
    logic [10:0]   q_val;
    logic [11:0]   s_nxt;

    function automatic logic [10:0] q_rom(input logic [6:0] i);
        logic [10:0] q;
        q = '0;
        case (i)
            7'd0:  q = 11'd0;
            7'd1:  q = 11'd50;
            7'd2:  q = 11'd100;
            7'd3:  q = 11'd151;
            7'd4:  q = 11'd201;
            7'd5:  q = 11'd251;
            7'd6:  q = 11'd300;
            7'd7:  q = 11'd350;
            7'd8:  q = 11'd399;
            7'd9:  q = 11'd449;
            7'd10: q = 11'd497;
            7'd11: q = 11'd546;
            7'd12: q = 11'd594;
            7'd13: q = 11'd642;
            7'd14: q = 11'd690;
            7'd15: q = 11'd737;
            7'd16: q = 11'd783;
            7'd17: q = 11'd830;
            7'd18: q = 11'd875;
            7'd19: q = 11'd920;
            7'd20: q = 11'd965;
            7'd21: q = 11'd1009;
            7'd22: q = 11'd1052;
            7'd23: q = 11'd1095;
            7'd24: q = 11'd1137;
            7'd25: q = 11'd1179;
            7'd26: q = 11'd1219;
            7'd27: q = 11'd1259;
            7'd28: q = 11'd1299;
            7'd29: q = 11'd1337;
            7'd30: q = 11'd1375;
            7'd31: q = 11'd1411;
            7'd32: q = 11'd1447;
            7'd33: q = 11'd1483;
            7'd34: q = 11'd1517;
            7'd35: q = 11'd1550;
            7'd36: q = 11'd1582;
            7'd37: q = 11'd1614;
            7'd38: q = 11'd1644;
            7'd39: q = 11'd1674;
            7'd40: q = 11'd1702;
            7'd41: q = 11'd1729;
            7'd42: q = 11'd1756;
            7'd43: q = 11'd1781;
            7'd44: q = 11'd1805;
            7'd45: q = 11'd1828;
            7'd46: q = 11'd1850;
            7'd47: q = 11'd1871;
            7'd48: q = 11'd1891;
            7'd49: q = 11'd1910;
            7'd50: q = 11'd1927;
            7'd51: q = 11'd1944;
            7'd52: q = 11'd1959;
            7'd53: q = 11'd1973;
            7'd54: q = 11'd1986;
            7'd55: q = 11'd1997;
            7'd56: q = 11'd2008;
            7'd57: q = 11'd2017;
            7'd58: q = 11'd2025;
            7'd59: q = 11'd2032;
            7'd60: q = 11'd2037;
            7'd61: q = 11'd2041;
            7'd62: q = 11'd2045;
            7'd63: q = 11'd2046;
            7'd64: q = 11'd2047;
            default: q = 11'd0;
        endcase
        return q;
    endfunction

    assign idx_nxt = idx + STEP_W;

    // odd quadrants read the ROM backwards; offset 0 there lands on Q[64]
    assign q_addr = idx_nxt[6] ? (7'd64 - {1'b0, idx_nxt[5:0]})
                               : {1'b0, idx_nxt[5:0]};
    assign q_val  = q_rom(q_addr);

    // 2048 +/- Q spans 1..4095, so 12 bits never wrap
    assign s_nxt = idx_nxt[7] ? (12'd2048 - {1'b0, q_val})
                              : (12'd2048 + {1'b0, q_val});

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt <= '0;
            idx     <= '0;
            data    <= 12'd2048;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx_nxt;
            data    <= s_nxt;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_digital_sine_gen.sv
// Bench for digital_sine_gen: four parameterisations checked every cycle
// against a sine model derived with real arithmetic.
module tb_digital_sine_gen;

    logic        clk;
    logic        rst;
    logic [11:0] d_def;
    logic [11:0] d_fast;
    logic [11:0] d_hop;
    logic [11:0] d_odd;

    int total = 0;
    int bad   = 0;
    int sref[256];
    int n     = 0;
    bit armed = 0;
    int cap[257];
    int hop_pat[4];

    digital_sine_gen u_def (
        .Clk(clk), .Rst(rst), .data(d_def)
    );
    digital_sine_gen #(.CLK_DIV(2), .STEP(1)) u_fast (
        .Clk(clk), .Rst(rst), .data(d_fast)
    );
    digital_sine_gen #(.CLK_DIV(1), .STEP(64)) u_hop (
        .Clk(clk), .Rst(rst), .data(d_hop)
    );
    digital_sine_gen #(.CLK_DIV(3), .STEP(37)) u_odd (
        .Clk(clk), .Rst(rst), .data(d_odd)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int expect_at(input int div, input int step);
        return sref[((n / div) * step) % 256];
    endfunction

    // edges sampling Rst=0 since the most recent reset edge
    always @(posedge clk) begin
        if (rst) begin
            n     <= 0;
            armed <= 1;
        end else begin
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_def",  int'(d_def),  expect_at(488, 1));
            check("cyc_fast", int'(d_fast), expect_at(2, 1));
            check("cyc_hop",  int'(d_hop),  expect_at(1, 64));
            check("cyc_odd",  int'(d_odd),  expect_at(3, 37));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_chg;
        int prev;
        int len;
        real x;
        int r;

        for (int k = 0; k < 256; k++) begin
            x = 2047.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
            r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
            sref[k] = 2048 + r;
        end
        hop_pat[0] = 2048;
        hop_pat[1] = 4095;
        hop_pat[2] = 2048;
        hop_pat[3] = 1;

        rst = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_def",  int'(d_def),  2048);
            check("rst_hop",  int'(d_hop),  2048);
        end

        rst = 0;
        cap[0]   = int'(d_fast);
        last_chg = 0;
        prev     = int'(d_def);
        for (int e = 1; e <= 16 * 488; e++) begin
            @(posedge clk);
            #1;
            if (e % 2 == 0 && e / 2 <= 256)
                cap[e / 2] = int'(d_fast);
            if (e <= 8)
                check("hop_pat", int'(d_hop), hop_pat[e % 4]);
            if (e == 487)
                check("pre_first", int'(d_def), 2048);
            if (e == 488)
                check("first_smp", int'(d_def), 2098);
            if (e == 16 * 488)
                check("smp16", int'(d_def), 2831);
            if (int'(d_def) != prev) begin
                check("hold", e - last_chg, 488);
                last_chg = e;
                prev     = int'(d_def);
            end
        end

        check("smp0",   cap[0],   2048);
        check("smp32",  cap[32],  3495);
        check("peak",   cap[64],  4095);
        check("mid",    cap[128], 2048);
        check("trough", cap[192], 1);
        check("wrap",   cap[256], 2048);
        for (int k = 1; k < 256; k++)
            check("sym_odd", cap[k] + cap[256 - k], 4096);
        for (int k = 0; k <= 64; k++)
            check("sym_half", cap[k], cap[128 - k]);

        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(50, 2500)) @(posedge clk);
            #1;
            rst = 1;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                @(posedge clk);
                #1;
                check("mrst_def",  int'(d_def),  2048);
                check("mrst_fast", int'(d_fast), 2048);
                check("mrst_odd",  int'(d_odd),  2048);
            end
            rst = 0;
            for (int e = 1; e <= 488; e++) begin
                @(posedge clk);
                #1;
                if (e == 487)
                    check("mrst_hold", int'(d_def), 2048);
                if (e == 488)
                    check("mrst_first", int'(d_def), 2098);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
